// File: rtl/nios_custom_dma_debug_mon_master_if.sv
// Avalon-MM bus bundle between the debug monitor master and the system interconnect.
interface nios_custom_dma_debug_mon_master_if #(
  parameter int unsigned ADDR_W = 16
);
  logic [ADDR_W+1:0] avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic [3:0]        avm_byteenable;
  logic [31:0]       avm_readdata;
  logic              avm_waitrequest;

  modport master (
    output avm_address,
    output avm_read,
    output avm_write,
    output avm_writedata,
    output avm_byteenable,
    input  avm_readdata,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    input  avm_write,
    input  avm_writedata,
    input  avm_byteenable,
    output avm_readdata,
    output avm_waitrequest
  );
endinterface

// File: rtl/nios_custom_dma_debug_mon_master.sv
// Turns JTAG debug memory commands into single-word Avalon-MM reads/writes with
// address auto-increment and a waitrequest timeout; results go back to the debug slave.
module nios_custom_dma_debug_mon_master #(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [37:0]                                 jdo,
  input  logic                                        take_action_ocimem_a,
  input  logic                                        take_action_ocimem_b,
  input  logic                                        take_no_action_ocimem_a,
  output logic [31:0]                                 MonDReg,
  output logic                                        monitor_ready,
  output logic                                        monitor_error,
  nios_custom_dma_debug_mon_master_if.master          avm
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE
  } state_t;

  localparam logic [15:0] TIMEOUT = 16'(TIMEOUT_CYCLES);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       stall_cnt;
  logic              read_q;
  logic              write_q;
  logic [31:0]       writedata_q;
  logic              any_strobe;
  logic              unused_jdo;

  assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign unused_jdo = ^{jdo[37:36], jdo[1:0]};

  assign avm.avm_address    = {addr, 2'b00};
  assign avm.avm_read       = read_q;
  assign avm.avm_write      = write_q;
  assign avm.avm_writedata  = writedata_q;
  assign avm.avm_byteenable = 4'hF;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      addr          <= '0;
      stall_cnt     <= '0;
      read_q        <= 1'b0;
      write_q       <= 1'b0;
      writedata_q   <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take_action_ocimem_b) begin
            MonDReg       <= jdo[34:3];
            writedata_q   <= jdo[34:3];
            write_q       <= 1'b1;
            stall_cnt     <= '0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
            state         <= WRITE;
          end else if (take_action_ocimem_a) begin
            addr          <= jdo[ADDR_W+1:2];
            monitor_error <= 1'b0;
            if (jdo[35]) begin
              read_q        <= 1'b1;
              stall_cnt     <= '0;
              monitor_ready <= 1'b0;
              state         <= READ;
            end else begin
              // Address-only load has no bus phase, so it reports done at once.
              monitor_ready <= 1'b1;
            end
          end else if (take_no_action_ocimem_a) begin
            read_q        <= 1'b1;
            stall_cnt     <= '0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
            state         <= READ;
          end
        end

        READ, WRITE: begin
          // Any strobe here is dropped; the running transfer carries on untouched.
          if (any_strobe) begin
            monitor_error <= 1'b1;
          end
          if (!avm.avm_waitrequest) begin
            if (state == READ) begin
              MonDReg <= avm.avm_readdata;
            end
            addr          <= addr + ADDR_W'(1);
            read_q        <= 1'b0;
            write_q       <= 1'b0;
            monitor_ready <= 1'b1;
            state         <= IDLE;
          end else if (stall_cnt == TIMEOUT) begin
            read_q        <= 1'b0;
            write_q       <= 1'b0;
            monitor_ready <= 1'b1;
            monitor_error <= 1'b1;
            state         <= IDLE;
          end else begin
            stall_cnt <= stall_cnt + 16'd1;
          end
        end

        default: begin
          read_q  <= 1'b0;
          write_q <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
